game_countdown_timer: RTL and testbench
=======================================

Name: game_countdown_timer

Overview:
- Sits directly downstream of the free-running 12-bit game counter and consumes its count value.
- Turns the counter's wrap-around into a periodic base tick, prescales that tick to one-second steps, and runs a 2-digit BCD countdown (round timer) for the game.
- Start/pause control comes from debounced button pulses; digit outputs feed the seven-segment display stage.

Parameters:
- TICK_BIT, 11: bit of count_in whose 1->0 transition is one base tick; 11 means full 12-bit wrap.
- TICKS_PER_SEC, 12207: base ticks per one-second decrement; 50 MHz / 4096.
- PRESC_W, 14: prescaler width; must satisfy 2^PRESC_W >= TICKS_PER_SEC.
- START_TENS, 6: BCD tens digit loaded on start, 0-9.
- START_ONES, 0: BCD ones digit loaded on start, 0-9.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- count_in  in  12  count value from the upstream counter.
- start  in  1  single-cycle pulse: (re)load START digits and run.
- pause  in  1  single-cycle pulse: toggle RUN <-> PAUSE.
- secs_tens  out  4  BCD tens digit of remaining time.
- secs_ones  out  4  BCD ones digit of remaining time.
- tick_out  out  1  registered one-cycle base-tick pulse, any state.
- running  out  1  high in RUN.
- expired  out  1  high in DONE (level).
- expire_pulse  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; prev_bit=0; prescaler=0.
  - secs_tens=START_TENS, secs_ones=START_ONES.
  - tick_out=0, running=0, expired=0, expire_pulse=0.
  - Reset asserted mid-count returns to exactly these values, with no partial decrement.
- Tick detection:
  - prev_bit <= count_in[TICK_BIT] every cycle.
  - wrap = prev_bit & ~count_in[TICK_BIT] (combinational).
  - tick_out <= wrap, so tick_out has 1-cycle latency and is never held for more than 1 cycle per transition.
- States: IDLE, RUN, PAUSE, DONE. Control priority per cycle: start > pause > second-tick.
- start, from any state:
  - digits <= START digits; prescaler <= 0.
  - Next state RUN. If START digits are 00, next state is DONE and expire_pulse fires.
  - A coincident second boundary is discarded.
- RUN:
  - On wrap with prescaler==TICKS_PER_SEC-1: prescaler <= 0 and decrement the BCD digits.
  - Otherwise, on wrap: prescaler <= prescaler+1.
  - pause: go to PAUSE; prescaler and digits hold.
- BCD decrement:
  - ones!=0: ones-1.
  - ones==0: ones=9 and tens-1.
  - If the result is 00: next state DONE, expire_pulse=1 for exactly that edge's following cycle.
  - Digits never go below 00 and never wrap to 99.
- PAUSE: wraps are ignored for the prescaler (tick_out still pulses). pause returns to RUN, resuming from the held prescaler value.
- IDLE: wraps and pause are ignored.
- DONE: digits hold 00, expired=1, pause is ignored; only start or reset leave DONE.
- running == (state==RUN); expired == (state==DONE); both registered with the state.

Test Plan:
- Reset with count_in toggling -> all outputs at reset values, digits 6/0, tick_out 0 while reset low. Release reset with TICK_BIT=11 and count_in stepping 4095->0 -> tick_out high exactly 1 cycle, one cycle after the 0 appears.
- Overrides TICK_BIT=1, TICKS_PER_SEC=3, START=0/5; count_in increments by 1 each cycle; start pulse -> running=1 next cycle. Digits step 05->04->...->00, one step per 12 cycles. On reaching 00: expired=1, expire_pulse single cycle, running=0.
- Same setup, pause after 1 wrap of the second step -> digits hold for 40 cycles and tick_out keeps pulsing. Second pause -> the next decrement occurs after exactly 2 further wraps.
- START=1/0 countdown -> 10 goes to 09 on the first second boundary (ones borrow from tens), then 09->08.
- start and pause asserted in the same cycle, including coincident with a second boundary -> reload to START digits, state RUN, no decrement applied.
- In DONE, pulse pause -> no change. Pulse start -> digits reload, running=1. Assert reset mid-countdown -> IDLE, digits=START, prescaler cleared.

Source files
------------

// File: rtl/game_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : game_countdown_timer
// Description : Round timer for the game. Derives a base tick from the
//               upstream free-running counter's wrap, prescales it to
//               one-second steps and counts a 2-digit BCD value down to 00.
// Revision    : 1.0 - initial release
// ============================================================================
module game_countdown_timer #(
  parameter int TICK_BIT      = 11,
  parameter int TICKS_PER_SEC = 12207,
  parameter int PRESC_W       = 14,
  parameter int START_TENS    = 6,
  parameter int START_ONES    = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] count_in,
  input  logic        start,
  input  logic        pause,
  output logic [3:0]  secs_tens,
  output logic [3:0]  secs_ones,
  output logic        tick_out,
  output logic        running,
  output logic        expired,
  output logic        expire_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [PRESC_W-1:0] c_presc_last = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [PRESC_W-1:0] c_presc_one  = PRESC_W'(1);
  localparam logic [3:0]         c_start_tens = 4'(START_TENS);
  localparam logic [3:0]         c_start_ones = 4'(START_ONES);
  localparam logic               c_start_zero = (START_TENS == 0) && (START_ONES == 0);

  state_t               state_q, state_d;
  logic                 prev_bit_q, prev_bit_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [3:0]           tens_q, tens_d;
  logic [3:0]           ones_q, ones_d;
  logic                 tick_q, tick_d;
  logic                 running_q, running_d;
  logic                 expired_q, expired_d;
  logic                 expire_pulse_q, expire_pulse_d;

  logic                 w_wrap;
  logic [3:0]           w_dec_tens;
  logic [3:0]           w_dec_ones;
  logic                 w_dec_zero;
  logic                 w_at_zero;
  logic                 w_unused_count;

  // Only the tick bit matters; the rest of the upstream count is folded away.
  assign w_unused_count = ^count_in;

  // A base tick is the 1->0 transition of the selected count bit.
  assign w_wrap = prev_bit_q & ~count_in[TICK_BIT];

  // Edge-detect history and registered base-tick pulse.
  always_comb begin
    prev_bit_d = count_in[TICK_BIT];
    tick_d     = w_wrap;
  end

  // One-second BCD decrement: borrow from tens when ones is 0.
  always_comb begin
    w_dec_tens = tens_q;
    w_dec_ones = ones_q - 4'd1;
    if (ones_q == 4'd0) begin
      w_dec_ones = 4'd9;
      w_dec_tens = tens_q - 4'd1;
    end
  end

  assign w_dec_zero = (w_dec_tens == 4'd0) && (w_dec_ones == 4'd0);
  assign w_at_zero  = (tens_q == 4'd0) && (ones_q == 4'd0);

  // Next-state and datapath: start beats pause, pause beats the second tick.
  always_comb begin
    state_d        = state_q;
    presc_d        = presc_q;
    tens_d         = tens_q;
    ones_d         = ones_q;
    expire_pulse_d = 1'b0;

    if (start) begin
      tens_d  = c_start_tens;
      ones_d  = c_start_ones;
      presc_d = '0;
      if (c_start_zero) begin
        state_d        = ST_DONE;
        expire_pulse_d = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (w_wrap) begin
            if (presc_q == c_presc_last) begin
              presc_d = '0;
              if (w_at_zero) begin
                // Cannot normally occur; never let the digits wrap to 99.
                state_d        = ST_DONE;
                expire_pulse_d = 1'b1;
              end else begin
                tens_d = w_dec_tens;
                ones_d = w_dec_ones;
                if (w_dec_zero) begin
                  state_d        = ST_DONE;
                  expire_pulse_d = 1'b1;
                end
              end
            end else begin
              presc_d = presc_q + c_presc_one;
            end
          end
        end
        ST_PAUSE: begin
          if (pause) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          // IDLE and DONE only leave on start.
        end
      endcase
    end

    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      prev_bit_q     <= 1'b0;
      presc_q        <= '0;
      tens_q         <= c_start_tens;
      ones_q         <= c_start_ones;
      tick_q         <= 1'b0;
      running_q      <= 1'b0;
      expired_q      <= 1'b0;
      expire_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_bit_q     <= prev_bit_d;
      presc_q        <= presc_d;
      tens_q         <= tens_d;
      ones_q         <= ones_d;
      tick_q         <= tick_d;
      running_q      <= running_d;
      expired_q      <= expired_d;
      expire_pulse_q <= expire_pulse_d;
    end
  end

  assign secs_tens    = tens_q;
  assign secs_ones    = ones_q;
  assign tick_out     = tick_q;
  assign running      = running_q;
  assign expired      = expired_q;
  assign expire_pulse = expire_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_game_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_countdown_timer
// Description : Scoreboard bench for game_countdown_timer. Stimulus pushes
//               hand-computed output events (with their cycle) into queues;
//               monitors pop and compare whenever the outputs change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_countdown_timer;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] count_in;
  logic        start, pause, start_b, pause_b;

  logic [3:0]  tens_a, ones_a, tens_b, ones_b;
  logic        tick_a, run_a, exp_a, pul_a;
  logic        tick_b_unused, run_b, exp_b, pul_b;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [10:0] v; int c; } ev_t;
  typedef struct { logic v; int c; } tk_t;

  ev_t qa[$];
  ev_t qb[$];
  tk_t qt[$];

  logic [10:0] prev_a = 'x;
  logic [10:0] prev_b = 'x;

  // Unit A: START 0/5 countdown.
  game_countdown_timer #(
    .TICK_BIT(1), .TICKS_PER_SEC(3), .PRESC_W(14), .START_TENS(0), .START_ONES(5)
  ) dut (
    .clock(clock), .reset(reset), .count_in(count_in), .start(start), .pause(pause),
    .secs_tens(tens_a), .secs_ones(ones_a), .tick_out(tick_a), .running(run_a),
    .expired(exp_a), .expire_pulse(pul_a)
  );

  // Unit B: START 1/0 countdown (tens borrow).
  game_countdown_timer #(
    .TICK_BIT(1), .TICKS_PER_SEC(3), .PRESC_W(14), .START_TENS(1), .START_ONES(0)
  ) dut_b (
    .clock(clock), .reset(reset), .count_in(count_in), .start(start_b), .pause(pause_b),
    .secs_tens(tens_b), .secs_ones(ones_b), .tick_out(tick_b_unused), .running(run_b),
    .expired(exp_b), .expire_pulse(pul_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic push_a(input int t, input int o, input int r, input int x, input int p, input int c);
    ev_t ev;
    ev.v = {4'(t), 4'(o), 1'(r), 1'(x), 1'(p)};
    ev.c = c;
    qa.push_back(ev);
  endtask

  task automatic push_b(input int t, input int o, input int r, input int x, input int p, input int c);
    ev_t ev;
    ev.v = {4'(t), 4'(o), 1'(r), 1'(x), 1'(p)};
    ev.c = c;
    qb.push_back(ev);
  endtask

  task automatic push_t(input int c, input int v);
    tk_t tk;
    tk.v = 1'(v);
    tk.c = c;
    qt.push_back(tk);
  endtask

  // One clock of stimulus: count_in steps by one, control pulses applied.
  task automatic tick1(input int st, input int pz, input int stb, input int pzb);
    @(posedge clock);
    #1;
    count_in = count_in + 12'd1;
    start    = 1'(st);
    pause    = 1'(pz);
    start_b  = 1'(stb);
    pause_b  = 1'(pzb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick1(0, 0, 0, 0);
  endtask

  // Leaves count_in at a multiple of 4 so the next step puts it at phase 1.
  task automatic align();
    while (count_in[1:0] != 2'd0) tick1(0, 0, 0, 0);
  endtask

  // Monitor A: every change of the output tuple must match the next expected event.
  always @(negedge clock) begin : mon_a
    logic [10:0] cur;
    ev_t ev;
    cur = {tens_a, ones_a, run_a, exp_a, pul_a};
    if (cur !== prev_a) begin
      n_cmp++;
      if (qa.size() == 0) begin
        n_bad++;
        $display("FAIL a_event: got %h at cyc %0d, expected no change", cur, cyc);
      end else begin
        ev = qa.pop_front();
        if (cur !== ev.v || (ev.c >= 0 && ev.c != cyc)) begin
          n_bad++;
          $display("FAIL a_event: got %h at cyc %0d, expected %h at cyc %0d", cur, cyc, ev.v, ev.c);
        end
      end
    end
    prev_a = cur;
  end

  // Monitor B: same scheme for the 1/0 unit.
  always @(negedge clock) begin : mon_b
    logic [10:0] cur;
    ev_t ev;
    cur = {tens_b, ones_b, run_b, exp_b, pul_b};
    if (cur !== prev_b) begin
      n_cmp++;
      if (qb.size() == 0) begin
        n_bad++;
        $display("FAIL b_event: got %h at cyc %0d, expected no change", cur, cyc);
      end else begin
        ev = qb.pop_front();
        if (cur !== ev.v || (ev.c >= 0 && ev.c != cyc)) begin
          n_bad++;
          $display("FAIL b_event: got %h at cyc %0d, expected %h at cyc %0d", cur, cyc, ev.v, ev.c);
        end
      end
    end
    prev_b = cur;
  end

  // Tick monitor: checks tick_out on the cycles the stimulus scheduled.
  always @(negedge clock) begin : mon_t
    tk_t tk;
    if (qt.size() > 0 && qt[0].c == cyc) begin
      tk = qt.pop_front();
      n_cmp++;
      if (tick_a !== tk.v) begin
        n_bad++;
        $display("FAIL tick_out at cyc %0d: got %b, expected %b", cyc, tick_a, tk.v);
      end
    end
  end

  initial begin : stim
    int e;
    int p;
    reset    = 1'b0;
    count_in = 12'd0;
    start    = 1'b0;
    pause    = 1'b0;
    start_b  = 1'b0;
    pause_b  = 1'b0;

    // Reset values, with count_in toggling through wraps.
    push_a(0, 5, 0, 0, 0, -1);
    push_b(1, 0, 0, 0, 0, -1);
    repeat (8) begin
      tick1(0, 0, 0, 0);
      push_t(cyc + 1, 0);
    end

    // Release, then step the counter 4095 -> 0: one tick, one cycle later.
    @(posedge clock);
    #1;
    reset    = 1'b1;
    count_in = 12'hFFF;
    p = cyc;
    push_t(p + 1, 0);
    push_t(p + 2, 1);
    push_t(p + 3, 0);
    push_t(p + 4, 0);
    idle(6);

    // B: 10 -> 09 (borrow) -> 08, then pause to freeze it.
    align();
    tick1(0, 0, 1, 0);
    e = cyc + 1;
    push_b(1, 0, 1, 0, 0, e);
    push_b(0, 9, 1, 0, 0, e + 11);
    push_b(0, 8, 1, 0, 0, e + 23);
    push_b(0, 8, 0, 0, 0, e + 24);
    idle(23);
    tick1(0, 0, 0, 1);
    idle(30);

    // A: full 05 -> 00 countdown, 12 cycles per step.
    align();
    tick1(1, 0, 0, 0);
    e = cyc + 1;
    push_a(0, 5, 1, 0, 0, e);
    push_a(0, 4, 1, 0, 0, e + 11);
    push_a(0, 3, 1, 0, 0, e + 23);
    push_a(0, 2, 1, 0, 0, e + 35);
    push_a(0, 1, 1, 0, 0, e + 47);
    push_a(0, 0, 0, 1, 1, e + 59);
    push_a(0, 0, 0, 1, 0, e + 60);
    idle(75);

    // A: restart from DONE, pause one wrap into the second step.
    align();
    tick1(1, 0, 0, 0);
    e = cyc + 1;
    push_a(0, 5, 1, 0, 0, e);
    push_a(0, 4, 1, 0, 0, e + 11);
    push_a(0, 4, 0, 0, 0, e + 16);
    push_t(e + 19, 1);
    push_t(e + 20, 0);
    push_t(e + 22, 0);
    push_t(e + 23, 1);
    idle(15);
    tick1(0, 1, 0, 0);
    // Resume after 40 cycles: decrement after two more wraps.
    push_a(0, 4, 1, 0, 0, e + 56);
    push_a(0, 3, 1, 0, 0, e + 63);
    idle(39);
    tick1(0, 1, 0, 0);
    // start+pause on a second boundary: reload, no decrement.
    push_a(0, 5, 1, 0, 0, e + 75);
    push_a(0, 4, 1, 0, 0, e + 87);
    push_a(0, 3, 1, 0, 0, e + 99);
    push_a(0, 2, 1, 0, 0, e + 111);
    push_a(0, 1, 1, 0, 0, e + 123);
    push_a(0, 0, 0, 1, 1, e + 135);
    push_a(0, 0, 0, 1, 0, e + 136);
    idle(18);
    tick1(1, 1, 0, 0);
    idle(70);
    // pause in DONE: no output change expected.
    tick1(0, 1, 0, 0);
    idle(10);
    // start from DONE at counter phase 2: first decrement 10 cycles later.
    push_a(0, 5, 1, 0, 0, e + 157);
    push_a(0, 4, 1, 0, 0, e + 167);
    tick1(1, 0, 0, 0);
    idle(15);

    // Asynchronous reset mid-countdown.
    reset = 1'b0;
    p = cyc;
    push_a(0, 5, 0, 0, 0, p);
    push_b(1, 0, 0, 0, 0, p);
    idle(3);
    reset = 1'b1;
    idle(4);

    // Fresh start after reset: normal first step.
    align();
    tick1(1, 0, 0, 0);
    e = cyc + 1;
    push_a(0, 5, 1, 0, 0, e);
    push_a(0, 4, 1, 0, 0, e + 11);
    idle(16);

    // Every expected event must have been seen.
    n_cmp++;
    if (qa.size() != 0) begin
      n_bad++;
      $display("FAIL a_drain: %0d events left, expected 0", qa.size());
    end
    n_cmp++;
    if (qb.size() != 0) begin
      n_bad++;
      $display("FAIL b_drain: %0d events left, expected 0", qb.size());
    end
    n_cmp++;
    if (qt.size() != 0) begin
      n_bad++;
      $display("FAIL tick_drain: %0d checks left, expected 0", qt.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
